axi_input_adapter: RTL and testbench
====================================

AXI_INPUT_ADAPTER -- requirements
Module: axi_input_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter N, default 4, matrix dimension; each matrix is N*N elements.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  permits loading; low aborts any load in progress.
REQ-006 consume  input  1  consumer has taken the loaded operands; releases the buffers.
REQ-007 s_axis_tvalid  input  1  AXI-Stream slave valid.
REQ-008 s_axis_tdata  input  DATA_W  element; A elements then B elements, each row-major.
REQ-009 s_axis_tlast  input  1  marks the last element of each matrix.
REQ-010 s_axis_tready  output  1  AXI-Stream slave ready.
REQ-011 a_mat  output  [N][N]xDATA_W  operand A buffer.
REQ-012 b_mat  output  [N][N]xDATA_W  operand B buffer.
REQ-013 mat_valid  output  1  both buffers are complete and stable.
REQ-014 tlast_err  output  1  sticky framing-error flag.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD_A, LOAD_B and FULL.
REQ-016 IDLE->LOAD_A on the first edge with enable=1.
REQ-017 LOAD_A->LOAD_B on the handshake of element index N*N-1.
REQ-018 LOAD_B->FULL on the handshake of element index N*N-1.
REQ-019 FULL->IDLE on consume=1; consume is ignored in all other states.
REQ-020 s_axis_tready SHALL equal enable AND (state==LOAD_A OR state==LOAD_B), decoded combinationally from registered state.
REQ-021 Handshake = s_axis_tvalid AND s_axis_tready; only a handshake writes a buffer or advances the element counter.
REQ-022 Element counter SHALL be $clog2(N*N) bits wide, start at 0, and wrap to 0 on the A->B and B->FULL transitions.
REQ-023 Element index k SHALL be written to row k/N, col k%N of the active buffer.
REQ-024 mat_valid SHALL be 1 exactly while state==FULL, starting the cycle after the final B handshake.
REQ-025 a_mat and b_mat SHALL hold their values while state is FULL or IDLE; writes occur only in LOAD_A and LOAD_B respectively.
REQ-026 enable=0 in any state SHALL force state IDLE and counter 0 on the next edge; buffers are retained and mat_valid drops.
REQ-027 When enable=0 and consume=1 occur together, enable=0 takes priority; the result is IDLE.
REQ-028 Stalls (tvalid=0) of any length SHALL leave the counter and state unchanged.

Reset
REQ-029 When rst_n=0 at a clock edge: state IDLE, counter 0, all a_mat/b_mat elements 0, mat_valid 0, tlast_err 0.
REQ-030 While rst_n=0 is asserted, s_axis_tready SHALL be 0.
REQ-031 Reset asserted mid-load SHALL discard the partial load; the next load restarts at A element 0.

Configuration
REQ-032 Macro AXI_IN_TLAST_CHECK_EN SHALL control tlast checking.
REQ-033 With AXI_IN_TLAST_CHECK_EN defined, a handshake where s_axis_tlast != (counter==N*N-1) SHALL set tlast_err; tlast_err clears only on reset.
REQ-034 With AXI_IN_TLAST_CHECK_EN defined, the same mismatch SHALL also return the FSM to LOAD_A with counter 0, so the next element is A[0][0].
REQ-035 Without AXI_IN_TLAST_CHECK_EN, s_axis_tlast SHALL be ignored and tlast_err SHALL be tied to 0.

Verification
REQ-036 N=4, enable=1, 32 back-to-back beats 1..32 with tlast on beats 16 and 32 -> a_mat[0][0]=1, a_mat[3][3]=16, b_mat[0][0]=17, b_mat[3][3]=32; mat_valid=1 the cycle after beat 32; tready=0 in FULL.
REQ-037 Same stream with tvalid deasserted on every other cycle -> identical buffer contents; mat_valid rises one cycle after the 32nd handshake.
REQ-038 In FULL, pulse consume -> mat_valid=0 the next cycle; then a second stream 101..132 -> a_mat[0][0]=101.
REQ-039 Drop enable after beat 10, then restore it and send beats 1..32 -> no stale data; a_mat[2][1]=10 from the new stream; mat_valid asserts after beat 32.
REQ-040 AXI_IN_TLAST_CHECK_EN defined, tlast=1 on beat 5 -> tlast_err=1 and sticky; the next beat lands in a_mat[0][0]. Without the macro, the same stimulus -> tlast_err=0 and a normal load.
REQ-041 Assert rst_n=0 at beat 20, then release -> all outputs 0; a full 32-beat stream then loads correctly.

Source files
------------

// File: rtl/axi_input_adapter_if.sv
// AXI-Stream element channel feeding the matrix operand adapter.
interface axi_input_adapter_if #(
  parameter int DATA_W = 8
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);
endinterface

// File: rtl/axi_input_adapter.sv
// Collects an A then B N*N matrix from an AXI-Stream into operand buffers.
// Define AXI_IN_TLAST_CHECK_EN to enable tlast framing checks with resync.
module axi_input_adapter #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable,
  input  logic                               consume,
  axi_input_adapter_if.slave                 s_axis,
  output logic [N-1:0][N-1:0][DATA_W-1:0]    a_mat,
  output logic [N-1:0][N-1:0][DATA_W-1:0]    b_mat,
  output logic                               mat_valid,
  output logic                               tlast_err
);
  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FULL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hs, last_el, wr_a, wr_b;

  assign s_axis.tready = rst_n & enable & ((state_q == LOAD_A) | (state_q == LOAD_B));
  assign hs            = s_axis.tvalid & s_axis.tready;
  assign last_el       = (cnt_q == LAST);
  assign wr_a          = hs & (state_q == LOAD_A);
  assign wr_b          = hs & (state_q == LOAD_B);
  assign mat_valid     = (state_q == FULL);

`ifdef AXI_IN_TLAST_CHECK_EN
  logic err_q, err_d;
  assign tlast_err = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis.tlast;
  assign tlast_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
`ifdef AXI_IN_TLAST_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef AXI_IN_TLAST_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef AXI_IN_TLAST_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: state_d = LOAD_A;
      LOAD_A, LOAD_B: begin
        if (hs) begin
          if (last_el) begin
            cnt_d   = '0;
            state_d = (state_q == LOAD_A) ? LOAD_B : FULL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: if (consume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef AXI_IN_TLAST_CHECK_EN
    // A misframed beat restarts the whole A/B pair so the next beat is A[0][0].
    if (hs && (s_axis.tlast != last_el)) begin
      err_d   = 1'b1;
      state_d = LOAD_A;
      cnt_d   = '0;
    end
`endif
    // Dropping enable wins over everything, including consume.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // One register pair per element, written only when the counter selects it.
  for (genvar k = 0; k < NN; k++) begin : g_el
    logic [DATA_W-1:0] a_q, b_q;
    logic              sel;
    assign sel = (cnt_q == CW'(k));
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (wr_a && sel) a_q <= s_axis.tdata;
        if (wr_b && sel) b_q <= s_axis.tdata;
      end
    end
    assign a_mat[k/N][k%N] = a_q;
    assign b_mat[k/N][k%N] = b_q;
  end
endmodule

// File: tb/tb_axi_input_adapter.sv
// Directed bench for axi_input_adapter (N=4, DATA_W=8).
module tb_axi_input_adapter;
  localparam int DATA_W = 8;
  localparam int N      = 4;

  logic clk = 1'b0;
  logic rst_n, enable, consume;
  logic [N-1:0][N-1:0][DATA_W-1:0] a_mat, b_mat;
  logic mat_valid, tlast_err;
  int checks = 0;
  int errors = 0;

  axi_input_adapter_if #(.DATA_W(DATA_W)) s_axis ();

  axi_input_adapter #(.DATA_W(DATA_W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .consume   (consume),
    .s_axis    (s_axis),
    .a_mat     (a_mat),
    .b_mat     (b_mat),
    .mat_valid (mat_valid),
    .tlast_err (tlast_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one beat from a falling edge and returns just after the capturing edge.
  task automatic beat(input logic [7:0] d, input logic l, input bit gap);
    int t;
    if (gap) begin
      @(negedge clk);
      s_axis.tvalid = 1'b0;
    end
    @(negedge clk);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    t = 0;
    while (!s_axis.tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $error("FAIL tready_timeout: observed 0 expected 1");
    end
    @(posedge clk);
  endtask

  // 32 beats base..base+31, tlast on beats 16 and 32; ends on the following falling edge.
  task automatic stream(input logic [7:0] base, input bit gap, input string tag);
    for (int i = 1; i <= 32; i++) begin
      if (i == 32) begin
        #1;
        chk({tag, "_mv_before_last"}, mat_valid, 1'b0);
      end
      beat(base + 8'(i - 1), (i == 16) || (i == 32), gap);
    end
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic pulse_consume();
    @(negedge clk);
    consume = 1'b1;
    @(negedge clk);
    consume = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; consume = 1'b0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis.tready, 1'b0);
    chk("rst_mv", mat_valid, 1'b0);
    chk("rst_err", tlast_err, 1'b0);
    chk("rst_a00", a_mat[0][0], 8'd0);
    chk("rst_b33", b_mat[3][3], 8'd0);
    rst_n = 1'b1;

    // Back-to-back load
    stream(8'd1, 1'b0, "b2b");
    chk("b2b_a00", a_mat[0][0], 8'd1);
    chk("b2b_a33", a_mat[3][3], 8'd16);
    chk("b2b_a21", a_mat[2][1], 8'd10);
    chk("b2b_b00", b_mat[0][0], 8'd17);
    chk("b2b_b33", b_mat[3][3], 8'd32);
    chk("b2b_mv", mat_valid, 1'b1);
    chk("b2b_tready_full", s_axis.tready, 1'b0);
    repeat (3) @(negedge clk);
    chk("full_hold_mv", mat_valid, 1'b1);
    chk("full_hold_tready", s_axis.tready, 1'b0);

    // Consume releases, buffers held in IDLE
    pulse_consume();
    chk("consume_mv", mat_valid, 1'b0);
    chk("consume_a00_held", a_mat[0][0], 8'd1);

    // Second stream with a stall before every beat
    stream(8'd101, 1'b1, "gap");
    chk("gap_a00", a_mat[0][0], 8'd101);
    chk("gap_a33", a_mat[3][3], 8'd116);
    chk("gap_b00", b_mat[0][0], 8'd117);
    chk("gap_b33", b_mat[3][3], 8'd132);
    chk("gap_mv", mat_valid, 1'b1);

    // enable low together with consume in FULL
    @(negedge clk);
    enable = 1'b0; consume = 1'b1;
    @(negedge clk);
    chk("en_cons_mv", mat_valid, 1'b0);
    chk("en_cons_tready", s_axis.tready, 1'b0);
    chk("en_cons_b33_held", b_mat[3][3], 8'd132);
    enable = 1'b1; consume = 1'b0;

    // Abort after 10 beats, then reload
    for (int i = 1; i <= 10; i++) beat(8'(49 + i), 1'b0, 1'b0);
    @(negedge clk);
    s_axis.tvalid = 1'b0; enable = 1'b0;
    @(negedge clk);
    chk("abort_tready", s_axis.tready, 1'b0);
    chk("abort_mv", mat_valid, 1'b0);
    chk("abort_a21_kept", a_mat[2][1], 8'd59);
    enable = 1'b1;
    stream(8'd1, 1'b0, "reload");
    chk("reload_a21", a_mat[2][1], 8'd10);
    chk("reload_a00", a_mat[0][0], 8'd1);
    chk("reload_b33", b_mat[3][3], 8'd32);
    chk("reload_mv", mat_valid, 1'b1);

    // Early tlast on beat 5
    pulse_consume();
    for (int i = 1; i <= 5; i++) beat(8'(59 + i), (i == 5), 1'b0);
`ifdef AXI_IN_TLAST_CHECK_EN
    @(negedge clk);
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    chk("tl_err_set", tlast_err, 1'b1);
    chk("tl_tready", s_axis.tready, 1'b1);
    stream(8'd1, 1'b0, "tl_resync");
    chk("tl_resync_a00", a_mat[0][0], 8'd1);
    chk("tl_resync_a10", a_mat[1][0], 8'd5);
    chk("tl_resync_b33", b_mat[3][3], 8'd32);
    chk("tl_resync_mv", mat_valid, 1'b1);
    chk("tl_err_sticky", tlast_err, 1'b1);
`else
    for (int i = 6; i <= 32; i++) beat(8'(59 + i), (i == 16) || (i == 32), 1'b0);
    @(negedge clk);
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
    chk("tl_err_off", tlast_err, 1'b0);
    chk("tl_off_a00", a_mat[0][0], 8'd60);
    chk("tl_off_a10", a_mat[1][0], 8'd64);
    chk("tl_off_b00", b_mat[0][0], 8'd76);
    chk("tl_off_b33", b_mat[3][3], 8'd91);
    chk("tl_off_mv", mat_valid, 1'b1);
`endif

    // Reset mid-load at beat 20
    pulse_consume();
    for (int i = 1; i <= 19; i++) beat(8'(i), (i == 16), 1'b0);
    @(negedge clk);
    s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_a00", a_mat[0][0], 8'd0);
    chk("mrst_a33", a_mat[3][3], 8'd0);
    chk("mrst_b00", b_mat[0][0], 8'd0);
    chk("mrst_b33", b_mat[3][3], 8'd0);
    chk("mrst_mv", mat_valid, 1'b0);
    chk("mrst_err", tlast_err, 1'b0);
    chk("mrst_tready", s_axis.tready, 1'b0);
    rst_n = 1'b1;
    stream(8'd1, 1'b0, "post_rst");
    chk("post_rst_a00", a_mat[0][0], 8'd1);
    chk("post_rst_a33", a_mat[3][3], 8'd16);
    chk("post_rst_b00", b_mat[0][0], 8'd17);
    chk("post_rst_b33", b_mat[3][3], 8'd32);
    chk("post_rst_mv", mat_valid, 1'b1);
    chk("post_rst_err", tlast_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
